// File: rtl/oled_pattern_gen.sv
// Registered four-mode test-pattern source for the SSD1331 video path; mode and scroll change only at frame boundaries.
// Optional macro OLED_PATTERN_BORDER_EN forces a white one-pixel border over every mode.
module oled_pattern_gen #(
  parameter int          C_x_size       = 96,
  parameter int          C_y_size       = 64,
  parameter int          C_color_bits   = 16,
  parameter int          C_square_log2  = 3,
  parameter int          C_scroll_shift = 2,
  parameter logic [15:0] C_fg_color     = 16'h07E0,
  parameter logic [15:0] C_bg_color     = 16'hF800
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(C_x_size)-1:0] x,
  input  logic [$clog2(C_y_size)-1:0] y,
  input  logic [1:0]                  mode_req,
  input  logic                        mode_strobe,
  output logic [C_color_bits-1:0]     color,
  output logic                        frame_tick,
  output logic [1:0]                  mode
);

  localparam int XW = $clog2(C_x_size);
  localparam int YW = $clog2(C_y_size);
  localparam logic [XW-1:0] XMAX = XW'(C_x_size - 1);
  localparam logic [YW-1:0] YMAX = YW'(C_y_size - 1);
  localparam logic [XW:0]   XLIM = (XW+1)'(C_x_size);
  localparam logic [YW:0]   YLIM = (YW+1)'(C_y_size);
  localparam logic [XW-1:0] XONE = XW'(1);
  localparam logic [C_scroll_shift-1:0] CNT_ONE = C_scroll_shift'(1);

  typedef enum logic [1:0] {
    PAT_CHECKER  = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_SCROLL   = 2'd3
  } pattern_e;

  logic [XW-1:0]             prev_x_q;
  logic [YW-1:0]             prev_y_q;
  pattern_e                  mode_q, mode_d;
  pattern_e                  pending_q, pending_d;
  logic                      pending_valid_q, pending_valid_d;
  logic [C_scroll_shift-1:0] frame_cnt_q, frame_cnt_d;
  logic [XW-1:0]             offset_q, offset_d;
  logic [C_color_bits-1:0]   color_q, color_d;
  logic                      boundary;
  logic [XW-1:0]             xs, px;
  logic                      sq, outside;
  logic [15:0]               rgb565;

  assign boundary   = (x == '0) && (y == '0) && (prev_x_q == XMAX) && (prev_y_q == YMAX);
  assign frame_tick = boundary && !reset;
  assign mode       = mode_q;
  assign color      = color_q;

  // A strobe always takes priority, so a request arriving on a boundary waits for the next one.
  always_comb begin
    mode_d          = mode_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    frame_cnt_d     = frame_cnt_q;
    offset_d        = offset_q;
    if (mode_strobe) begin
      pending_d       = pattern_e'(mode_req);
      pending_valid_d = 1'b1;
    end else if (boundary && pending_valid_q) begin
      mode_d          = pending_q;
      pending_valid_d = 1'b0;
    end
    if (boundary) begin
      frame_cnt_d = frame_cnt_q + CNT_ONE;
      if (&frame_cnt_q) begin
        offset_d = offset_q + XONE;
      end
    end
  end

  // Next-state mode and offset are used so pixel (0,0) of a new frame already reflects them.
  always_comb begin
    xs      = x + offset_d;
    px      = (mode_d == PAT_SCROLL) ? xs : x;
    sq      = px[C_square_log2] ^ y[C_square_log2];
    outside = ({1'b0, x} >= XLIM) || ({1'b0, y} >= YLIM);
    rgb565  = '0;
    case (mode_d)
      PAT_BARS:     rgb565 = {{5{x[XW-1]}}, {6{x[XW-2]}}, {5{x[XW-3]}}};
      PAT_GRADIENT: rgb565 = {x[XW-1:XW-5], 6'd0, y[YW-1:YW-5]};
      default:      rgb565 = sq ? C_fg_color : C_bg_color;
    endcase
    if (outside) begin
      rgb565 = '0;
    end
`ifdef OLED_PATTERN_BORDER_EN
    else if ((x == '0) || (x == XMAX) || (y == '0) || (y == YMAX)) begin
      rgb565 = '1;
    end
`endif
  end

  generate
    if (C_color_bits == 8) begin : g_rgb332
      assign color_d = {rgb565[15:13], rgb565[10:8], rgb565[4:3]};
    end else begin : g_rgb565
      assign color_d = rgb565[C_color_bits-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_x_q        <= '0;
      prev_y_q        <= '0;
      mode_q          <= PAT_CHECKER;
      pending_q       <= PAT_CHECKER;
      pending_valid_q <= 1'b0;
      frame_cnt_q     <= '0;
      offset_q        <= '0;
      color_q         <= '0;
    end else begin
      prev_x_q        <= x;
      prev_y_q        <= y;
      mode_q          <= mode_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      frame_cnt_q     <= frame_cnt_d;
      offset_q        <= offset_d;
      color_q         <= color_d;
    end
  end

endmodule

// File: doc/oled_pattern_gen.md
# oled_pattern_gen

Parametrised, registered test-pattern source for the SSD1331 OLED video path. It sits between the top level and `oled_video`. It takes the driver's current scan coordinate `x`,`y` and returns a pixel `color` one clock later. It supports four selectable patterns, one of which scrolls. It tracks frame boundaries so that mode changes and animation happen only between frames, never mid-frame.

## Interface
- `C_x_size`, 96: visible columns.
- `C_y_size`, 64: visible rows.
- `C_color_bits`, 16: pixel format. 16 = RGB565, 8 = RGB332; any other value is illegal.
- `C_square_log2`, 3: checker square edge = 2^N pixels.
- `C_scroll_shift`, 2: scroll offset advances once every 2^N frames.
- `C_fg_color`, 16'h07E0: checker "on" colour (RGB565; truncated for 8-bit).
- `C_bg_color`, 16'hF800: checker "off" colour (RGB565; truncated for 8-bit).
- `clk`  in  1  pixel/driver clock.
- `reset`  in  1  synchronous, active-high reset.
- `x`  in  XW = clog2(C_x_size)  scan column from `oled_video`.
- `y`  in  YW = clog2(C_y_size)  scan row from `oled_video`.
- `mode_req`  in  2  requested pattern.
- `mode_strobe`  in  1  one-cycle pulse that latches `mode_req` as pending.
- `color`  out  C_color_bits  registered pixel colour for the previous cycle's `x`,`y`.
- `frame_tick`  out  1  one-cycle pulse at each frame boundary.
- `mode`  out  2  active pattern.

## Operation
- **Frame boundary:** the block registers the previous `x`,`y`. A boundary occurs when the current coordinate is (0,0) and the previous one is (C_x_size-1, C_y_size-1). On that cycle `frame_tick` = 1.
- **Mode pending register:** `mode_strobe` loads `mode_req` into `pending` and sets `pending_valid`.
  - On a boundary with `pending_valid`: `mode` ← `pending` and `pending_valid` clears.
  - If a strobe and a boundary occur in the same cycle, the strobe wins: the new request stays pending and is applied at the next boundary. Any earlier pending value is overwritten.
- **Frame counter:** `frame_cnt` is C_scroll_shift bits wide and increments on each boundary. When it wraps to 0, `offset` (XW bits) increments modulo 2^XW.
- **Patterns** (16-bit components shown):
  - Mode 0, checkered: `sq` = x[S] ^ y[S], where S = C_square_log2. Output `C_fg_color` if `sq`, else `C_bg_color`.
  - Mode 1, bars: i = x[XW-1:XW-3]. R = 5{i[2]}, G = 6{i[1]}, B = 5{i[0]}.
  - Mode 2, gradient: R = x[XW-1:XW-5], G = 0, B = y[YW-1:YW-5].
  - Mode 3, scrolling checker: as mode 0, using xs = (x + offset) mod 2^XW in place of x.
- **8-bit output:** RGB332 = {R[4:2], G[5:3], B[4:3]}.
- Coordinates outside the visible area (x ≥ C_x_size or y ≥ C_y_size) output 0.

## Timing
- **Latency:** `color` is valid 1 clock after `x`,`y`. `oled_video` holds each coordinate for many clocks, so no stall handshake is required.
- **Reset values:** `color` = 0, `mode` = 0, `frame_tick` = 0, `pending_valid` = 0, `offset` = 0, `frame_cnt` = 0. The previous-coordinate register resets to (0,0), so the first frame after reset produces no tick.
- **Reset mid-frame:** all state clears on the next edge. Pattern output resumes from the current `x`,`y` one cycle after reset deasserts.
- **Mode switch:** the new `mode` is visible on the cycle after `frame_tick`. The first `color` of the new frame (pixel 0,0) already uses the new mode.
- **Offset update:** `offset` updates on the same edge as the mode switch and also applies to pixel (0,0).

## Configuration
- `OLED_PATTERN_BORDER_EN` defined: pixels with x = 0, x = C_x_size-1, y = 0 or y = C_y_size-1 output all-ones (white), overriding every mode.
- Undefined: no border logic is compiled; edge pixels follow the active pattern.

## Test plan
- Reset, mode 0, C_square_log2 = 3: (x,y) = (8,0) → `color` 16'h07E0 one cycle later; (8,8) → 16'hF800.
- Mode 1: x = 80 (i = 5) → `color` 16'hF81F; x = 16 (i = 1) → 16'h001F.
- `mode_strobe` with `mode_req` = 2 mid-frame: `mode` stays 0 until scan passes (95,63)→(0,0). `frame_tick` pulses once, then `mode` = 2, and (0,0) outputs 0.
- Mode 3, C_scroll_shift = 2: after 4 boundaries `offset` = 1, and (7,0) renders like mode 0 at (8,0). After 512 boundaries `offset` wraps to 0.
- Strobe and boundary in the same cycle: `mode` unchanged at this boundary; request applied at the following boundary.
- With `OLED_PATTERN_BORDER_EN`, mode 2: (0,10) → 16'hFFFF, (95,63) → 16'hFFFF, (10,10) → gradient value. Without the macro, (0,10) → gradient value.
